// File: rtl/jtdd_snd_cmd_pkg.sv
// Shared types and helpers for the sound command link.
//  cmd_t      : one command byte as written by the main CPU
//  tmr_width  : bit width able to hold counts 0 .. max(a,b)-1 (at least 1 bit)
package jtdd_snd_cmd_pkg;

  typedef logic [7:0] cmd_t;

  function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/jtdd_snd_cmd_if.sv
// Bus between the main CPU / sound CPU side and the sound command block.
//  master : main CPU write port (cpu_cen, cs, cpu_dout) plus sound CPU latch-read (snd_ack);
//           observes snd_latch, snd_irq, busy, full, ovf
//  slave  : the command block itself
interface jtdd_snd_cmd_if;
  import jtdd_snd_cmd_pkg::*;

  logic cpu_cen;
  logic cs;
  cmd_t cpu_dout;
  cmd_t snd_latch;
  logic snd_irq;
  logic snd_ack;
  logic busy;
  logic full;
  logic ovf;

  modport master (
    output cpu_cen, cs, cpu_dout, snd_ack,
    input  snd_latch, snd_irq, busy, full, ovf
  );

  modport slave (
    input  cpu_cen, cs, cpu_dout, snd_ack,
    output snd_latch, snd_irq, busy, full, ovf
  );

endinterface

// File: rtl/jtdd_snd_cmd_fifo.sv
// Synchronous command FIFO, depth 2**AW, asynchronous active-low clear.
//  clk, rst_n : clock and async clear (pointers and count; storage is not cleared)
//  i_push     : write i_din; accepted when not full, or when full and popping the same clk
//  i_pop      : drop the head; ignored when empty
//  o_dout     : current head (valid while !o_empty)
//  o_full, o_empty, o_count : occupancy, o_count is AW+1 bits wide
module jtdd_snd_cmd_fifo
  import jtdd_snd_cmd_pkg::*;
#(
  parameter int unsigned AW = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  logic        i_pop,
  input  cmd_t        i_din,
  output cmd_t        o_dout,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_count
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [AW:0] CountFull = (AW + 1)'(Depth);

  cmd_t          r_mem [Depth];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_pop  = i_pop & (r_count != '0);
  // A pop in the same clk frees the slot, so a push at full still lands.
  assign w_do_push = i_push & ((r_count != CountFull) | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CountFull);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/jtdd_snd_cmd.sv
// Main-CPU side of the sound command link. Bytes written by the main CPU are queued and handed
// to the sound CPU one at a time on snd_latch; snd_irq rises once per command and stays high until
// the sound CPU reads the latch (snd_ack) or the optional timeout expires.
//  clk, rst_n : system clock, asynchronous active-low reset
//  bus        : slave side of jtdd_snd_cmd_if
//               cpu_cen/cs/cpu_dout in, snd_ack in (asynchronous level),
//               snd_latch/snd_irq/busy/full/ovf out
// Parameters: AW (FIFO depth 2**AW), GAP_LEN (min irq-low clks between commands, >=1),
//             TIMEOUT (max clks in HOLD before forced release, 0 = never).
module jtdd_snd_cmd
  import jtdd_snd_cmd_pkg::*;
#(
  parameter int unsigned AW      = 2,
  parameter int unsigned GAP_LEN = 8,
  parameter int unsigned TIMEOUT = 0
) (
  input logic            clk,
  input logic            rst_n,
  jtdd_snd_cmd_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StHold, StGap} state_e;

  localparam int unsigned  TW          = tmr_width(GAP_LEN, TIMEOUT);
  localparam logic [TW-1:0] GapLast     = TW'(GAP_LEN - 1);
  localparam logic [TW-1:0] TimeoutLast = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e        r_state, w_state_d;
  cmd_t          r_latch, w_latch_d;
  logic          r_irq, w_irq_d;
  logic [TW-1:0] r_timer, w_timer_d;
  logic          r_ovf;
  logic          r_ack_meta, r_ack_sync, r_ack_dly;

  logic          w_req;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_count;
  cmd_t          w_head;
  logic          w_ack_rise;
  logic          w_ovf_d;

  assign w_req = bus.cs & bus.cpu_cen;

  jtdd_snd_cmd_fifo #(
    .AW (AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_req),
    .i_pop   (w_pop),
    .i_din   (bus.cpu_dout),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Dropped only when full and no pop frees a slot in the same clk.
  assign w_ovf_d    = w_req & w_full & ~w_pop;
  assign w_ack_rise = r_ack_sync & ~r_ack_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_meta <= 1'b0;
      r_ack_sync <= 1'b0;
      r_ack_dly  <= 1'b0;
      r_ovf      <= 1'b0;
      r_state    <= StIdle;
      r_latch    <= '0;
      r_irq      <= 1'b0;
      r_timer    <= '0;
    end else begin
      r_ack_meta <= bus.snd_ack;
      r_ack_sync <= r_ack_meta;
      r_ack_dly  <= r_ack_sync;
      r_ovf      <= w_ovf_d;
      r_state    <= w_state_d;
      r_latch    <= w_latch_d;
      r_irq      <= w_irq_d;
      r_timer    <= w_timer_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_latch_d = r_latch;
    w_irq_d   = r_irq;
    w_timer_d = r_timer;
    w_pop     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_latch_d = w_head;
          w_state_d = StSetup;
        end
      end
      // Latch has been stable for a full clk before the irq edge.
      StSetup: begin
        w_irq_d   = 1'b1;
        w_timer_d = '0;
        w_state_d = StHold;
      end
      StHold: begin
        if (TIMEOUT != 0) w_timer_d = r_timer + 1'b1;
        if (w_ack_rise || ((TIMEOUT != 0) && (r_timer == TimeoutLast))) begin
          w_irq_d   = 1'b0;
          w_timer_d = '0;
          w_state_d = StGap;
        end
      end
      // Timer saturates at GapLast; a still-asserted ack keeps us here so the next
      // irq edge cannot be merged with the current read.
      StGap: begin
        if (r_timer != GapLast) begin
          w_timer_d = r_timer + 1'b1;
        end else if (!r_ack_sync) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign bus.snd_latch = r_latch;
  assign bus.snd_irq   = r_irq;
  assign bus.ovf       = r_ovf;
  assign bus.full      = w_full;
  assign bus.busy      = (w_count != '0) | (r_state != StIdle);

endmodule
